// File: rtl/addr_cycle_monitor.sv
// Address-FIFO event gap monitor: publishes the last gap between events and a
// saturating histogram of gaps, gated by program run/active control and freeze.
module addr_cycle_monitor #(
    parameter  int MON_CNT_RANGE = 8,
    parameter  int MON_CNT_SIZE  = 16,
    parameter  int MAX_CYCLE_CNT = 128,
    localparam int NUM_BINS      = MAX_CYCLE_CNT / MON_CNT_RANGE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_program,
    input  logic                    active_program,
    input  logic                    freeze,
    input  logic                    event_strobe,
    output logic [15:0]             cycle_cnt,
    output logic [MON_CNT_SIZE-1:0] mon_cnts [NUM_BINS],
    output logic [31:0]             event_total,
    output logic                    bin_saturated
);
    localparam int SHIFT = $clog2(MON_CNT_RANGE);
    localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } state_t;

    state_t                  state_q, state_d;
    logic                    run_q, run_d;
    logic                    act_q, act_d;
    logic [15:0]             gap_cnt_q, gap_cnt_d;
    logic [15:0]             cycle_cnt_q, cycle_cnt_d;
    logic [MON_CNT_SIZE-1:0] bins_q [NUM_BINS];
    logic [MON_CNT_SIZE-1:0] bins_d [NUM_BINS];
    logic [31:0]             total_q, total_d;
    logic                    sat_q, sat_d;

    logic                    start;
    logic                    act_fall;
    logic                    ev;
    logic [15:0]             bin_sel;
    logic [IDX_W-1:0]        idx;
    logic [MON_CNT_SIZE-1:0] bin_next;

    function automatic logic [MON_CNT_SIZE-1:0] bin_inc(input logic [MON_CNT_SIZE-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] total_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] gap_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    // Gaps beyond the covered range all land in the last bin.
    always_comb begin
        bin_sel = gap_cnt_q >> SHIFT;
        if (bin_sel >= 16'(NUM_BINS)) begin
            idx = IDX_W'(NUM_BINS - 1);
        end else begin
            idx = bin_sel[IDX_W-1:0];
        end
    end

    always_comb begin
        run_d       = run_program;
        act_d       = active_program;
        start       = run_program & ~run_q;
        act_fall    = act_q & ~active_program;
        ev          = event_strobe & ~freeze;
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        bins_d      = bins_q;
        total_d     = total_q;
        sat_d       = sat_q;
        bin_next    = bin_inc(bins_q[idx]);

        if (start) begin
            state_d     = WAIT_FIRST;
            gap_cnt_d   = '0;
            cycle_cnt_d = '0;
            bins_d      = '{default: '0};
            total_d     = '0;
            sat_d       = 1'b0;
        end else begin
            case (state_q)
                WAIT_FIRST: begin
                    if (ev) begin
                        gap_cnt_d = 16'd1;
                        total_d   = total_inc(total_q);
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (ev) begin
                        cycle_cnt_d = gap_cnt_q;
                        bins_d[idx] = bin_next;
                        if (bin_next == '1) begin
                            sat_d = 1'b1;
                        end
                        total_d   = total_inc(total_q);
                        gap_cnt_d = 16'd1;
                    end else if (!freeze) begin
                        gap_cnt_d = gap_inc(gap_cnt_q);
                    end
                end
                default: begin
                end
            endcase
            // An event in the same cycle as the fall is still recorded above.
            if (act_fall && (state_q != IDLE)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            act_q       <= 1'b0;
            gap_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            bins_q      <= '{default: '0};
            total_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            act_q       <= act_d;
            gap_cnt_q   <= gap_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            bins_q      <= bins_d;
            total_q     <= total_d;
            sat_q       <= sat_d;
        end
    end

    assign cycle_cnt     = cycle_cnt_q;
    assign mon_cnts      = bins_q;
    assign event_total   = total_q;
    assign bin_saturated = sat_q;

endmodule

// File: tb/tb_addr_cycle_monitor.sv
// Bench for addr_cycle_monitor: a gap model built on a count of unfrozen cycles,
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_addr_cycle_monitor;
    localparam int NB    = 16;
    localparam int RANGE = 8;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        run_program    = 1'b0;
    logic        active_program = 1'b0;
    logic        freeze         = 1'b0;
    logic        event_strobe   = 1'b0;

    logic [15:0] cycle_cnt, cycle_cnt_s;
    logic [15:0] mon_cnts   [NB];
    logic [3:0]  mon_cnts_s [NB];
    logic [31:0] event_total, event_total_s;
    logic        bin_saturated, bin_saturated_s;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    addr_cycle_monitor dut (
        .clk           (clk),
        .reset         (reset),
        .run_program   (run_program),
        .active_program(active_program),
        .freeze        (freeze),
        .event_strobe  (event_strobe),
        .cycle_cnt     (cycle_cnt),
        .mon_cnts      (mon_cnts),
        .event_total   (event_total),
        .bin_saturated (bin_saturated)
    );

    // Narrow-bin instance so bin saturation is reachable in a short run.
    addr_cycle_monitor #(.MON_CNT_SIZE(4)) dut_s (
        .clk           (clk),
        .reset         (reset),
        .run_program   (run_program),
        .active_program(active_program),
        .freeze        (freeze),
        .event_strobe  (event_strobe),
        .cycle_cnt     (cycle_cnt_s),
        .mon_cnts      (mon_cnts_s),
        .event_total   (event_total_s),
        .bin_saturated (bin_saturated_s)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 waiting for first event, 2 measuring.
    int     m_mode;
    longint m_live, m_last, m_total, gap;
    int     m_cyc, b;
    int     m_bin   [NB];
    int     m_bin_s [NB];
    bit     m_sat, m_sat_s, m_run_prev, m_act_prev, st, fall, evm;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_live = 0; m_last = 0; m_total = 0; m_cyc = 0;
            m_sat = 0; m_sat_s = 0; m_run_prev = 0; m_act_prev = 0;
            for (int i = 0; i < NB; i++) begin
                m_bin[i] = 0;
                m_bin_s[i] = 0;
            end
        end else begin
            st   = run_program && !m_run_prev;
            fall = m_act_prev && !active_program;
            evm  = event_strobe && !freeze;
            if (st) begin
                m_mode = 1; m_live = 0; m_last = 0; m_total = 0; m_cyc = 0;
                m_sat = 0; m_sat_s = 0;
                for (int i = 0; i < NB; i++) begin
                    m_bin[i] = 0;
                    m_bin_s[i] = 0;
                end
            end else if (m_mode != 0) begin
                if (evm) begin
                    if (m_total < 64'hFFFF_FFFF) m_total = m_total + 1;
                    if (m_mode == 2) begin
                        gap = m_live - m_last;
                        if (gap > 65535) gap = 65535;
                        m_cyc = int'(gap);
                        b = int'(gap / RANGE);
                        if (b > NB - 1) b = NB - 1;
                        if (m_bin[b] < 65535) begin
                            m_bin[b] = m_bin[b] + 1;
                            if (m_bin[b] == 65535) m_sat = 1;
                        end
                        if (m_bin_s[b] < 15) begin
                            m_bin_s[b] = m_bin_s[b] + 1;
                            if (m_bin_s[b] == 15) m_sat_s = 1;
                        end
                    end
                    m_last = m_live;
                    m_mode = 2;
                end
                if (!freeze) m_live = m_live + 1;
                if (fall) m_mode = 0;
            end
            m_run_prev = run_program;
            m_act_prev = active_program;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            check("event_total", 64'(event_total), 64'(m_total));
            check("bin_saturated", 64'(bin_saturated), 64'(m_sat));
            check("cycle_cnt_s", 64'(cycle_cnt_s), 64'(m_cyc));
            check("event_total_s", 64'(event_total_s), 64'(m_total));
            check("bin_saturated_s", 64'(bin_saturated_s), 64'(m_sat_s));
            for (int i = 0; i < NB; i++) begin
                check($sformatf("bin%0d", i), 64'(mon_cnts[i]), 64'(m_bin[i]));
                check($sformatf("bin%0d_s", i), 64'(mon_cnts_s[i]), 64'(m_bin_s[i]));
            end
        end
    end

    task automatic step(input logic ev);
        event_strobe = ev;
        @(posedge clk);
        #1;
        event_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic restart();
        run_program = 1'b0;
        step(1'b0);
        run_program = 1'b1;
        step(1'b0);
    endtask

    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("rst_event_total", 64'(event_total), 64'd0);
        check("rst_bin_saturated", 64'(bin_saturated), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Events at relative cycles 10, 11, 20 after start
        active_program = 1'b1;
        run_program    = 1'b1;
        step(1'b0);
        idle(9); step(1'b1); step(1'b1); idle(8); step(1'b1);
        #1;
        check("t1_cycle_cnt", 64'(cycle_cnt), 64'd9);
        check("t1_bin0", 64'(mon_cnts[0]), 64'd1);
        check("t1_bin1", 64'(mon_cnts[1]), 64'd1);
        check("t1_total", 64'(event_total), 64'd3);

        // Long gaps into the catch-all bin and bin edges
        idle(199); step(1'b1);
        #1;
        check("t2_cycle_200", 64'(cycle_cnt), 64'd200);
        check("t2_bin15_a", 64'(mon_cnts[15]), 64'd1);
        idle(126); step(1'b1);
        idle(119); step(1'b1);
        #1;
        check("t2_cycle_120", 64'(cycle_cnt), 64'd120);
        check("t2_bin15_c", 64'(mon_cnts[15]), 64'd3);
        idle(118); step(1'b1);
        idle(6);   step(1'b1);
        idle(7);   step(1'b1);
        #1;
        check("t2_bin14", 64'(mon_cnts[14]), 64'd1);
        check("t2_bin0", 64'(mon_cnts[0]), 64'd2);
        check("t2_bin1", 64'(mon_cnts[1]), 64'd2);
        check("t2_total", 64'(event_total), 64'd9);

        // Bin saturation on the narrow instance
        restart();
        step(1'b1);
        repeat (14) step(1'b1);
        #1;
        check("t3_bin0_s_e", 64'(mon_cnts_s[0]), 64'hE);
        check("t3_sat_s_pre", 64'(bin_saturated_s), 64'd0);
        step(1'b1); step(1'b1); step(1'b1);
        #1;
        check("t3_bin0_s_f", 64'(mon_cnts_s[0]), 64'hF);
        check("t3_sat_s", 64'(bin_saturated_s), 64'd1);
        check("t3_bin0", 64'(mon_cnts[0]), 64'd17);
        check("t3_sat", 64'(bin_saturated), 64'd0);
        idle(20);
        #1;
        check("t3_sat_s_held", 64'(bin_saturated_s), 64'd1);
        restart();
        #1;
        check("t3_sat_s_clr", 64'(bin_saturated_s), 64'd0);

        // Freeze between events
        step(1'b1); idle(4); step(1'b1);
        idle(2);
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) step(1'((i % 7) == 3));
        freeze = 1'b0;
        idle(2); step(1'b1);
        #1;
        check("t4_cycle_cnt", 64'(cycle_cnt), 64'd5);
        check("t4_total", 64'(event_total), 64'd3);
        check("t4_bin0", 64'(mon_cnts[0]), 64'd2);

        // active_program fall with a coincident event, then ignored events
        idle(2);
        active_program = 1'b0;
        step(1'b1);
        step(1'b1); idle(3); step(1'b1);
        #1;
        check("t5_cycle_cnt", 64'(cycle_cnt), 64'd3);
        check("t5_total", 64'(event_total), 64'd4);
        active_program = 1'b1;
        restart();
        #1;
        check("t5_clr_total", 64'(event_total), 64'd0);
        check("t5_clr_bin0", 64'(mon_cnts[0]), 64'd0);
        step(1'b1);
        #1;
        check("t5_first_total", 64'(event_total), 64'd1);
        check("t5_first_cycle", 64'(cycle_cnt), 64'd0);
        idle(3);
        run_program = 1'b0;
        step(1'b0);
        run_program = 1'b1;
        step(1'b1);
        #1;
        check("t5_start_wins", 64'(event_total), 64'd0);

        // Asynchronous reset mid-gap
        step(1'b1); idle(3); step(1'b1); idle(5);
        @(posedge clk); #3;
        run_program = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("t6_total", 64'(event_total), 64'd0);
        check("t6_bin0", 64'(mon_cnts[0]), 64'd0);
        check("t6_bin_s0", 64'(mon_cnts_s[0]), 64'd0);
        idle(2);
        reset = 1'b1;
        step(1'b1); idle(2); step(1'b1);
        #1;
        check("t6_ignored", 64'(event_total), 64'd0);
        run_program = 1'b1;
        step(1'b0);
        step(1'b1); idle(1); step(1'b1);
        #1;
        check("t6_after_cycle", 64'(cycle_cnt), 64'd2);
        check("t6_after_total", 64'(event_total), 64'd2);
        idle(3);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
